// File: rtl/wm_pkg.sv
// Shared encodings for the washing-machine front end and controller.
// Latency: none (types and constants only).
// Backpressure: none.
package wm_pkg;

   // Coin acceptor states
   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_PAID    = 2'd1,
      ST_REFUND  = 2'd2
   } acc_state_t;

   // Default pricing and debounce settings
   localparam int DEF_PRICE           = 4;
   localparam int DEF_DEBOUNCE_CYCLES = 8;

   // Controller state constants (owned by the downstream controller)
   typedef enum logic [2:0] {
      CTL_IDLE  = 3'd0,
      CTL_READY = 3'd1,
      CTL_FILL  = 3'd2,
      CTL_WASH  = 3'd3,
      CTL_RINSE = 3'd4,
      CTL_SPIN  = 3'd5
   } ctl_state_t;

endpackage

// File: rtl/wm_debounce.sv
// Synchronizes and debounces the raw coin sensor, emits a pulse on each debounced rise.
// Latency: raw rise -> rise_pulse after 2 + DEBOUNCE_CYCLES clocks.
// Backpressure: none; pulses shorter than DEBOUNCE_CYCLES are dropped.
import wm_pkg::*;

module wm_debounce #(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_W            = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw_in,
   output logic level_out,
   output logic rise_pulse
);

   logic            sync1;
   logic            sync2;
   logic [DB_W-1:0] cnt;
   logic            differ;
   logic            accept;

   assign differ = (sync2 != level_out);
   assign accept = differ && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));

   // Two-flop synchronizer for the asynchronous sensor input
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw_in;
         sync2 <= sync1;
      end
   end

   // Count consecutive differing samples; adopt the new level once the run is long enough
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         level_out  <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         rise_pulse <= accept && sync2;
         if (accept) begin
            level_out <= sync2;
            cnt       <= '0;
         end else if (differ) begin
            cnt <= cnt + DB_W'(1);
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/wm_coin_acceptor.sv
// Counts debounced coins into credit, raises paid flag at PRICE, ejects coins on cancel/excess.
// Latency: coin_raw rise -> credit update 11 clocks; coin follows credit==PRICE by 1 clock.
// Backpressure: none; refunds eject one coin every other cycle, excess coins while paid are returned.
import wm_pkg::*;

module wm_coin_acceptor #(
   parameter int PRICE           = DEF_PRICE,
   parameter int CNT_W           = 3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int DB_W            = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             coin_raw,
   input  logic             cancel,
   input  logic             cycle_start,
   output logic             coin,
   output logic             coin_Return,
   output logic [CNT_W-1:0] credit,
   output logic             refunding
);

   localparam logic [CNT_W-1:0] PRICE_C = CNT_W'(PRICE);

   acc_state_t       state, state_n;
   logic [CNT_W-1:0] credit_n;
   logic [CNT_W-1:0] credit_inc;
   logic [CNT_W-1:0] credit_dec;
   logic             gap, gap_n;
   logic             ret_n;
   logic             coin_level;
   logic             coin_rise;
   logic             coin_evt;

   wm_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_W            (DB_W)
   ) u_db (
      .clock      (clock),
      .reset      (reset),
      .raw_in     (coin_raw),
      .level_out  (coin_level),
      .rise_pulse (coin_rise)
   );

   // A rise is only honoured while the debounced level reads high
   assign coin_evt   = coin_rise && coin_level;
   assign credit_inc = credit + CNT_W'(coin_evt);
   assign credit_dec = credit - CNT_W'(1) + CNT_W'(coin_evt);
   assign refunding  = (state == ST_REFUND);

   // Next-state, next-credit and ejection decision
   always_comb begin
      state_n  = state;
      credit_n = credit;
      gap_n    = gap;
      ret_n    = 1'b0;
      unique case (state)
         ST_COLLECT: begin
            credit_n = credit_inc;
            // Cancel wins over reaching PRICE: a completing coin is refunded too
            if (cancel && (credit_inc != '0)) begin
               state_n = ST_REFUND;
               gap_n   = 1'b0;
            end else if (coin_evt && (credit_inc == PRICE_C)) begin
               state_n = ST_PAID;
            end
         end
         ST_PAID: begin
            // Excess coin goes straight back out; credit stays at PRICE
            ret_n = coin_evt;
            if (cycle_start) begin
               credit_n = '0;
               state_n  = ST_COLLECT;
            end else if (cancel) begin
               state_n = ST_REFUND;
               // An excess ejection this cycle acts as a pulse, so start on a gap
               gap_n   = coin_evt;
            end
         end
         ST_REFUND: begin
            if (!gap) begin
               ret_n    = 1'b1;
               credit_n = credit_dec;
               gap_n    = 1'b1;
            end else if (coin_evt && (credit == PRICE_C)) begin
               // Credit is full: eject the new coin now and keep the gap phase
               ret_n = 1'b1;
            end else begin
               credit_n = credit_inc;
               if (credit_inc == '0) begin
                  state_n = ST_COLLECT;
               end else begin
                  gap_n = 1'b0;
               end
            end
         end
         default: begin
            state_n = ST_COLLECT;
         end
      endcase
   end

   // State, credit and output registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= ST_COLLECT;
         credit      <= '0;
         gap         <= 1'b0;
         coin_Return <= 1'b0;
         coin        <= 1'b0;
      end else begin
         state       <= state_n;
         credit      <= credit_n;
         gap         <= gap_n;
         coin_Return <= ret_n;
         coin        <= (state == ST_PAID);
      end
   end

endmodule

// File: tb/tb_wm_coin_acceptor.sv
// Directed bench for wm_coin_acceptor with immediate-assertion checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_wm_coin_acceptor;

   logic       clock;
   logic       reset;
   logic       coin_raw;
   logic       cancel;
   logic       cycle_start;
   logic       coin;
   logic       coin_Return;
   logic [2:0] credit;
   logic       refunding;

   int checks = 0;
   int errors = 0;
   int pulses;

   wm_coin_acceptor #(
      .PRICE           (4),
      .CNT_W           (3),
      .DEBOUNCE_CYCLES (8),
      .DB_W            (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .coin_raw    (coin_raw),
      .cancel      (cancel),
      .cycle_start (cycle_start),
      .coin        (coin),
      .coin_Return (coin_Return),
      .credit      (credit),
      .refunding   (refunding)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic insert_coin(input int hi, input int lo);
      coin_raw = 1'b1;
      tick(hi);
      coin_raw = 1'b0;
      tick(lo);
   endtask

   initial begin
      reset       = 1'b1;
      coin_raw    = 1'b0;
      cancel      = 1'b0;
      cycle_start = 1'b0;
      tick(3);
      check("rst_credit", 8'(credit), 8'd0);
      check("rst_coin", 8'(coin), 8'd0);
      check("rst_ret", 8'(coin_Return), 8'd0);
      check("rst_refunding", 8'(refunding), 8'd0);
      reset = 1'b0;
      tick(2);

      // First coin: event 10 cycles after rise, credit visible one cycle later
      coin_raw = 1'b1;
      tick(10);
      check("lat_before", 8'(credit), 8'd0);
      tick(1);
      check("lat_after", 8'(credit), 8'd1);
      tick(9);
      coin_raw = 1'b0;
      tick(20);
      insert_coin(20, 20);
      check("coin2_credit", 8'(credit), 8'd2);
      insert_coin(20, 20);
      check("coin3_credit", 8'(credit), 8'd3);

      // Fourth coin reaches PRICE; coin flag follows one cycle later
      coin_raw = 1'b1;
      tick(11);
      check("coin4_credit", 8'(credit), 8'd4);
      check("coin4_flag_early", 8'(coin), 8'd0);
      tick(1);
      check("coin4_flag", 8'(coin), 8'd1);
      tick(8);
      coin_raw = 1'b0;
      tick(20);

      // Excess coin while paid
      coin_raw = 1'b1;
      tick(11);
      check("excess_ret", 8'(coin_Return), 8'd1);
      check("excess_credit", 8'(credit), 8'd4);
      check("excess_coin", 8'(coin), 8'd1);
      tick(1);
      check("excess_ret_end", 8'(coin_Return), 8'd0);
      tick(8);
      coin_raw = 1'b0;
      tick(20);

      // cycle_start consumes the credit
      cycle_start = 1'b1;
      tick(1);
      cycle_start = 1'b0;
      check("cs_credit", 8'(credit), 8'd0);
      check("cs_coin_hold", 8'(coin), 8'd1);
      tick(1);
      check("cs_coin", 8'(coin), 8'd0);

      // Bouncy coin: three short glitches then a solid level
      for (int g = 0; g < 3; g++) begin
         coin_raw = 1'b1;
         tick(3);
         coin_raw = 1'b0;
         tick(3);
      end
      insert_coin(20, 20);
      check("bounce_credit", 8'(credit), 8'd1);
      insert_coin(5, 20);
      check("short_pulse", 8'(credit), 8'd1);

      // Refund of three coins
      insert_coin(20, 20);
      insert_coin(20, 20);
      check("pre_refund", 8'(credit), 8'd3);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      check("refund_enter", 8'(refunding), 8'd1);
      check("refund_enter_ret", 8'(coin_Return), 8'd0);
      for (int k = 1; k <= 6; k++) begin
         tick(1);
         check($sformatf("refund_ret_%0d", k), 8'(coin_Return), 8'((k % 2) == 1));
         check($sformatf("refund_credit_%0d", k), 8'(credit), 8'(3 - (k + 1) / 2));
         check($sformatf("refund_busy_%0d", k), 8'(refunding), 8'(k < 6));
         check($sformatf("refund_coin_%0d", k), 8'(coin), 8'd0);
      end

      // Paid: cycle_start and cancel together -> no refund
      for (int c = 0; c < 4; c++) insert_coin(20, 20);
      check("paid_again", 8'(coin), 8'd1);
      cycle_start = 1'b1;
      cancel      = 1'b1;
      tick(1);
      cycle_start = 1'b0;
      cancel      = 1'b0;
      check("cs_cancel_credit", 8'(credit), 8'd0);
      check("cs_cancel_ret", 8'(coin_Return), 8'd0);
      check("cs_cancel_busy", 8'(refunding), 8'd0);
      tick(1);
      check("cs_cancel_ret2", 8'(coin_Return), 8'd0);

      // Coin event coincident with cancel at credit 3 -> four coins back
      for (int c = 0; c < 3; c++) insert_coin(20, 20);
      coin_raw = 1'b1;
      tick(10);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      check("coincide_credit", 8'(credit), 8'd4);
      check("coincide_busy", 8'(refunding), 8'd1);
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (coin_Return === 1'b1) pulses++;
         check($sformatf("coincide_coin_%0d", k), 8'(coin), 8'd0);
      end
      check("coincide_pulses", 8'(pulses), 8'd4);
      check("coincide_done", 8'(refunding), 8'd0);
      check("coincide_credit0", 8'(credit), 8'd0);
      coin_raw = 1'b0;
      tick(20);

      // Reset in the middle of a refund
      for (int c = 0; c < 3; c++) insert_coin(20, 20);
      cancel = 1'b1;
      tick(1);
      cancel = 1'b0;
      tick(2);
      check("mid_refund_credit", 8'(credit), 8'd2);
      #2;
      reset = 1'b1;
      #1;
      check("arst_credit", 8'(credit), 8'd0);
      check("arst_ret", 8'(coin_Return), 8'd0);
      check("arst_busy", 8'(refunding), 8'd0);
      check("arst_coin", 8'(coin), 8'd0);
      tick(1);
      reset = 1'b0;
      pulses = 0;
      for (int k = 0; k < 8; k++) begin
         tick(1);
         if (coin_Return === 1'b1) pulses++;
      end
      check("post_rst_pulses", 8'(pulses), 8'd0);
      check("post_rst_busy", 8'(refunding), 8'd0);
      insert_coin(20, 20);
      check("post_rst_collect", 8'(credit), 8'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
